// File: rtl/debug_link_pkg.sv
// Shared definitions for the board/host debug link.
// Used by the board-side frame transmitter (debug_frame_tx) and the
// host-side receiver/decoder, so both ends agree on framing.
//   DBG_SYNC_BYTE   : first byte of every frame
//   DBG_NUM_PORTS   : number of 8-bit debug ports carried per frame
//   DBG_FRAME_BYTES : sync + ports + checksum
//   dbg_frame_state_e : frame sequencer state encoding
//   dbg_checksum()  : 8-bit wrap-around sum of the port bytes
package debug_link_pkg;

  localparam logic [7:0] DBG_SYNC_BYTE   = 8'hA5;
  localparam int         DBG_NUM_PORTS   = 7;
  localparam int         DBG_FRAME_BYTES = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } dbg_frame_state_e;

  // Element 0 holds port1, element 6 holds port7.
  typedef logic [DBG_NUM_PORTS-1:0][7:0] dbg_ports_t;

  // The sync byte is deliberately not part of the sum.
  function automatic logic [7:0] dbg_checksum(input dbg_ports_t ports);
    logic [7:0] sum;
    sum = 8'h00;
    for (int i = 0; i < DBG_NUM_PORTS; i++) begin
      sum = sum + ports[i];
    end
    return sum;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 UART serializer.
// Emits start bit (0), d0..d7 LSB first, stop bit (1); each bit held for
// CLKS_PER_BIT cycles. Line idles high.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   load           : accept data_byte when ready is high
//   data_byte[7:0] : byte to send
//   tx             : registered serial output
//   ready          : high when idle, and also during the last cycle of the
//                    stop bit so a following load produces a back-to-back
//                    start bit with no idle gap
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data_byte,
  output logic       tx,
  output logic       ready
);

  localparam int              CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]      BIT_LAST_DATA = 4'd8;
  localparam logic [3:0]      BIT_STOP      = 4'd9;

  logic             tx_q, tx_d;
  logic             active_q, active_d;
  logic [3:0]       bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             bit_end;

  assign bit_end = (cnt_q == CNT_LAST);
  assign ready   = !active_q || (bit_end && (bit_idx_q == BIT_STOP));
  assign tx      = tx_q;

  always_comb begin
    tx_d      = tx_q;
    active_d  = active_q;
    bit_idx_d = bit_idx_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    if (load && ready) begin
      active_d  = 1'b1;
      bit_idx_d = 4'd0;
      cnt_d     = '0;
      tx_d      = 1'b0;
      shift_d   = data_byte;
    end else if (active_q) begin
      if (bit_end) begin
        cnt_d = '0;
        if (bit_idx_q == BIT_STOP) begin
          active_d = 1'b0;
          tx_d     = 1'b1;
        end else begin
          bit_idx_d = bit_idx_q + 4'd1;
          // Leaving the last data bit drives the stop bit; otherwise the
          // next data bit comes off the bottom of the shift register.
          tx_d      = (bit_idx_q == BIT_LAST_DATA) ? 1'b1 : shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_q      <= 1'b1;
      active_q  <= 1'b0;
      bit_idx_q <= 4'd0;
      cnt_q     <= '0;
      shift_q   <= 8'h00;
    end else begin
      tx_q      <= tx_d;
      active_q  <= active_d;
      bit_idx_q <= bit_idx_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
    end
  end

endmodule

// File: rtl/debug_frame_tx.sv
// Board-side debug frame transmitter.
// Snapshots the seven cpu debug ports on an accepted start and sends
//   A5, port1..port7, checksum   as back-to-back 8N1 bytes on tx.
// Ports:
//   clk, reset               : clock, synchronous active-high reset
//   start                    : frame request, accepted only in IDLE
//   debug_port1..7 [7:0]     : debug bytes, captured on acceptance
//   tx                       : UART TX pin (idle high)
//   busy                     : high from the cycle after acceptance to the
//                              end of the final stop bit
//   done                     : one-cycle pulse as busy falls
//
// state | meaning
// IDLE  | line idle, waiting for start
// SEND  | serializing byte idx (0 = sync, 1..7 = ports, 8 = checksum)
// DONE  | frame finished, done pulse visible, one cycle before IDLE
module debug_frame_tx
  import debug_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] debug_port1,
  input  logic [7:0] debug_port2,
  input  logic [7:0] debug_port3,
  input  logic [7:0] debug_port4,
  input  logic [7:0] debug_port5,
  input  logic [7:0] debug_port6,
  input  logic [7:0] debug_port7,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] LAST_IDX = 4'(DBG_FRAME_BYTES - 1);

  dbg_frame_state_e state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  dbg_ports_t       snap_q, snap_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  dbg_ports_t       ports_in;
  logic [7:0]       checksum;
  logic [3:0]       next_idx;
  logic [2:0]       port_sel;
  logic [7:0]       next_byte;
  logic             ser_load;
  logic [7:0]       ser_byte;
  logic             ser_ready;
  logic             ser_tx;

  assign ports_in = {debug_port7, debug_port6, debug_port5, debug_port4,
                     debug_port3, debug_port2, debug_port1};
  assign checksum = dbg_checksum(snap_q);

  // Byte for the slot following the current one; only used while in SEND,
  // where next_idx is always 1..8.
  assign next_idx = idx_q + 4'd1;
  assign port_sel = 3'(next_idx - 4'd1);

  always_comb begin
    if (next_idx == LAST_IDX) begin
      next_byte = checksum;
    end else begin
      next_byte = snap_q[port_sel];
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    snap_d   = snap_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    ser_load = 1'b0;
    ser_byte = DBG_SYNC_BYTE;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          // The sync byte is loaded on the acceptance edge so its start bit
          // is on the line in the very next cycle.
          snap_d   = ports_in;
          idx_d    = 4'd0;
          busy_d   = 1'b1;
          state_d  = ST_SEND;
          ser_load = 1'b1;
          ser_byte = DBG_SYNC_BYTE;
        end
      end
      ST_SEND: begin
        if (ser_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d    = next_idx;
            ser_load = 1'b1;
            ser_byte = next_byte;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= 4'd0;
      snap_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx_byte (
    .clk      (clk),
    .reset    (reset),
    .load     (ser_load),
    .data_byte(ser_byte),
    .tx       (ser_tx),
    .ready    (ser_ready)
  );

  assign tx   = ser_tx;
  assign busy = busy_q;
  assign done = done_q;

endmodule
